ps2_ascii_queue: RTL and testbench
==================================

PS2_ASCII_QUEUE -- requirements
Module: ps2_ascii_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, minimum 2.
REQ-002 SHALL have parameter LOWER_CASE, default 1: 1 = case follows shift; 0 = letters always uppercase.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port byte_valid  input  1  one-cycle strobe marking a received PS/2 byte.
REQ-006 SHALL have port byte_data  input  8  received PS/2 byte, qualified by byte_valid.
REQ-007 SHALL have port rd_en  input  1  pop request for the head entry.
REQ-008 SHALL have port ascii_out  output  8  head entry (first-word-fall-through); 0x00 when empty.
REQ-009 SHALL have port empty  output  1  FIFO holds no entries.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 SHALL have port overflow  output  1  sticky flag: a character was dropped because the FIFO was full.
REQ-013 SHALL have port shift_active  output  1  left (0x12) or right (0x59) shift is held.

Function
REQ-014 Parser FSM states SHALL be IDLE, EXT, BRK and EXT_BRK; it advances only on cycles with byte_valid=1.
REQ-015 Transitions SHALL be: IDLE: 0xE0->EXT, 0xF0->BRK, other->make, stay IDLE; EXT: 0xF0->EXT_BRK, other->extended make, ->IDLE; BRK: any->break, ->IDLE; EXT_BRK: any->extended break, ->IDLE.
REQ-016 A make of 0x12 or 0x59 SHALL set the matching shift flag; the matching break SHALL clear it; shift codes are never enqueued.
REQ-017 Extended makes and breaks SHALL be consumed without enqueuing and SHALL NOT change the shift flags.
REQ-018 Non-shift make codes SHALL map as follows:
- Letters A–Z (set 2 codes 0x1C..0x1A) -> 0x41–0x5A when shift_active=1 or LOWER_CASE=0, else 0x61–0x7A.
- Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> 0x30–0x39, shift ignored.
- 0x29 -> 0x20; 0x5A -> 0x0D; 0x66 -> 0x08.
REQ-019 Unmapped make codes and all break codes SHALL be dropped without enqueuing.
REQ-020 A mapped make on cycle N SHALL be written at the end of cycle N; empty deasserts and ascii_out is valid in cycle N+1.
REQ-021 rd_en with empty=0 SHALL advance the head at that clock edge; rd_en with empty=1 SHALL be ignored.
REQ-022 Push with full=1 and no pop SHALL drop the character and set overflow; overflow clears only on reset.
REQ-023 Simultaneous push and pop SHALL both succeed, including when full, leaving count unchanged; simultaneous push and pop when empty SHALL perform the push only.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count SHALL equal the number of entries at all times.
REQ-025 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both registered consistently with count.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL enter the reset state:
- FSM -> IDLE; pointers and count -> 0.
- empty=1, full=0, overflow=0, shift flags=0, ascii_out=0x00.
- Typematic register cleared.
REQ-027 Reset during a prefix sequence (EXT/BRK/EXT_BRK) SHALL discard the partial sequence; the next byte is parsed from IDLE.

Configuration
REQ-028 Macro TYPEMATIC_FILTER_EN defined: a held-key register SHALL store the last non-shift make code; a repeated make equal to it SHALL be dropped; its break or any different make SHALL replace or clear it.
REQ-029 Macro TYPEMATIC_FILTER_EN undefined: every mapped make SHALL be enqueued, including auto-repeats, and no held-key register SHALL exist.

Verification
REQ-030 Bytes 0x1C, 0xF0, 0x1C with LOWER_CASE=1 -> one entry, ascii_out=0x61, count=1.
REQ-031 Bytes 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C -> entries 0x41 then 0x61; shift_active=1 after first byte, 0 after sixth.
REQ-032 Bytes 0xE0, 0x75, 0xE0, 0xF0, 0x75, 0x29 -> single entry 0x20; FSM back in IDLE.
REQ-033 DEPTH=4: push 5 mapped makes with no pops -> full=1, count=4, overflow=1, first four characters retained in order; then push and pop in the same cycle -> count stays 4.
REQ-034 With TYPEMATIC_FILTER_EN: bytes 0x1B, 0x1B, 0x1B -> count=1; without the macro the same bytes -> count=3.
REQ-035 Drive rst=0 after byte 0xF0 -> next byte 0x1C is treated as a make (count=1); all flags read their reset values during reset.

Source files
------------

// File: rtl/ps2_ascii_queue.sv
// PS/2 set-2 scan-code parser feeding an ASCII FIFO (first-word-fall-through); optional TYPEMATIC_FILTER_EN drops key auto-repeats.
// Latency: a mapped make seen on cycle N is readable on ascii_out in cycle N+1.
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped and sets sticky overflow.
module ps2_ascii_queue #(
    parameter int DEPTH      = 16,
    parameter bit LOWER_CASE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     rd_en,
    output logic [7:0]               ascii_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     shift_active
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          state_q, state_d;
    logic            lshift_q, lshift_d;
    logic            rshift_q, rshift_d;
    logic            make_vld, brk_vld, is_shift;
    logic            push_req, pop, do_push, repeat_hit;
    logic [8:0]      mapped;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;

    // Returns {hit, ascii}; hit=0 for codes with no character.
    function automatic logic [8:0] map_code(input logic [7:0] code, input logic upper);
        logic [7:0] base;
        logic [8:0] r;
        base = upper ? 8'h41 : 8'h61;
        r    = 9'h000;
        case (code)
            8'h1C: r = {1'b1, base + 8'd0};
            8'h32: r = {1'b1, base + 8'd1};
            8'h21: r = {1'b1, base + 8'd2};
            8'h23: r = {1'b1, base + 8'd3};
            8'h24: r = {1'b1, base + 8'd4};
            8'h2B: r = {1'b1, base + 8'd5};
            8'h34: r = {1'b1, base + 8'd6};
            8'h33: r = {1'b1, base + 8'd7};
            8'h43: r = {1'b1, base + 8'd8};
            8'h3B: r = {1'b1, base + 8'd9};
            8'h42: r = {1'b1, base + 8'd10};
            8'h4B: r = {1'b1, base + 8'd11};
            8'h3A: r = {1'b1, base + 8'd12};
            8'h31: r = {1'b1, base + 8'd13};
            8'h44: r = {1'b1, base + 8'd14};
            8'h4D: r = {1'b1, base + 8'd15};
            8'h15: r = {1'b1, base + 8'd16};
            8'h2D: r = {1'b1, base + 8'd17};
            8'h1B: r = {1'b1, base + 8'd18};
            8'h2C: r = {1'b1, base + 8'd19};
            8'h3C: r = {1'b1, base + 8'd20};
            8'h2A: r = {1'b1, base + 8'd21};
            8'h1D: r = {1'b1, base + 8'd22};
            8'h22: r = {1'b1, base + 8'd23};
            8'h35: r = {1'b1, base + 8'd24};
            8'h1A: r = {1'b1, base + 8'd25};
            8'h45: r = {1'b1, 8'h30};
            8'h16: r = {1'b1, 8'h31};
            8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33};
            8'h25: r = {1'b1, 8'h34};
            8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36};
            8'h3D: r = {1'b1, 8'h37};
            8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39};
            8'h29: r = {1'b1, 8'h20};
            8'h5A: r = {1'b1, 8'h0D};
            8'h66: r = {1'b1, 8'h08};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        make_vld = 1'b0;
        brk_vld  = 1'b0;
        if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (byte_data == 8'hE0)      state_d = EXT;
                    else if (byte_data == 8'hF0) state_d = BRK;
                    else                         make_vld = 1'b1;
                end
                // Extended makes/breaks are swallowed entirely.
                EXT:     state_d = (byte_data == 8'hF0) ? EXT_BRK : IDLE;
                BRK: begin
                    brk_vld = 1'b1;
                    state_d = IDLE;
                end
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign is_shift = (byte_data == 8'h12) || (byte_data == 8'h59);

    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        if (make_vld && byte_data == 8'h12) lshift_d = 1'b1;
        if (make_vld && byte_data == 8'h59) rshift_d = 1'b1;
        if (brk_vld  && byte_data == 8'h12) lshift_d = 1'b0;
        if (brk_vld  && byte_data == 8'h59) rshift_d = 1'b0;
    end

    assign shift_active = lshift_q | rshift_q;
    assign mapped       = map_code(byte_data, shift_active | ~LOWER_CASE);

`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] held_q, held_d;

    // 0x00 marks "no key held"; it is never a mapped code.
    always_comb begin
        held_d     = held_q;
        repeat_hit = 1'b0;
        if (make_vld && !is_shift) begin
            repeat_hit = (byte_data == held_q);
            held_d     = byte_data;
        end else if (brk_vld && byte_data == held_q) begin
            held_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) held_q <= 8'h00;
        else      held_q <= held_d;
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign push_req = make_vld && !is_shift && mapped[8] && !repeat_hit;
    assign pop      = rd_en && !empty_q;
    assign do_push  = push_req && (!full_q || pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !pop)      count_d = count_q + CW'(1);
        else if (!do_push && pop) count_d = count_q - CW'(1);
        empty_d  = (count_d == CW'(0));
        full_d   = (count_d == CW'(DEPTH));
        ovf_d    = ovf_q | (push_req && full_q && !pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= mapped[7:0];
    end

    assign ascii_out = empty_q ? 8'h00 : mem_q[rd_ptr_q];
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_ascii_queue.sv
// Directed bench: scan-code table through two DEPTH=4 instances (lower/upper case), then multi-cycle corner sequences.
module tb_ps2_ascii_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rd_en;

    logic [7:0] lc_ascii, uc_ascii;
    logic       lc_empty, lc_full, lc_ovf, lc_shift;
    logic       uc_empty, uc_full, uc_ovf, uc_shift;
    logic [2:0] lc_count, uc_count;

    int vec_cnt = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ps2_ascii_queue #(.DEPTH(4), .LOWER_CASE(1'b1)) dut_lc (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .rd_en(rd_en),
        .ascii_out(lc_ascii), .empty(lc_empty), .full(lc_full), .count(lc_count),
        .overflow(lc_ovf), .shift_active(lc_shift));

    ps2_ascii_queue #(.DEPTH(4), .LOWER_CASE(1'b0)) dut_uc (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .rd_en(rd_en),
        .ascii_out(uc_ascii), .empty(uc_empty), .full(uc_full), .count(uc_count),
        .overflow(uc_ovf), .shift_active(uc_shift));

    typedef struct {
        logic [7:0] code;
        logic [7:0] exp_lc;   // 0x00 means the code must not be enqueued
        logic [7:0] exp_uc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " empty"},    32'(lc_empty), 32'd1);
        chk({tag, " full"},     32'(lc_full),  32'd0);
        chk({tag, " overflow"}, 32'(lc_ovf),   32'd0);
        chk({tag, " shift"},    32'(lc_shift), 32'd0);
        chk({tag, " ascii"},    32'(lc_ascii), 32'h00);
        chk({tag, " count"},    32'(lc_count), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_q[4];

        vecs[0]  = '{8'h1C, 8'h61, 8'h41};
        vecs[1]  = '{8'h1A, 8'h7A, 8'h5A};
        vecs[2]  = '{8'h32, 8'h62, 8'h42};
        vecs[3]  = '{8'h4D, 8'h70, 8'h50};
        vecs[4]  = '{8'h45, 8'h30, 8'h30};
        vecs[5]  = '{8'h46, 8'h39, 8'h39};
        vecs[6]  = '{8'h16, 8'h31, 8'h31};
        vecs[7]  = '{8'h29, 8'h20, 8'h20};
        vecs[8]  = '{8'h5A, 8'h0D, 8'h0D};
        vecs[9]  = '{8'h66, 8'h08, 8'h08};
        vecs[10] = '{8'h76, 8'h00, 8'h00};
        vecs[11] = '{8'h0D, 8'h00, 8'h00};

        rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; rd_en = 1'b0;
        tick();
        chk_reset_vals("reset");
        tick();
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].code);
            if (vecs[i].exp_lc != 8'h00) begin
                chk($sformatf("tbl%0d lc_count", i), 32'(lc_count), 32'd1);
                chk($sformatf("tbl%0d lc_ascii", i), 32'(lc_ascii), 32'(vecs[i].exp_lc));
                chk($sformatf("tbl%0d uc_ascii", i), 32'(uc_ascii), 32'(vecs[i].exp_uc));
                pop_one();
                chk($sformatf("tbl%0d empty", i), 32'(lc_empty), 32'd1);
            end else begin
                chk($sformatf("tbl%0d dropped", i), 32'(lc_count), 32'd0);
                chk($sformatf("tbl%0d uc_dropped", i), 32'(uc_count), 32'd0);
            end
        end

        // Make, break, make-code byte of the break: one lowercase entry
        do_reset();
        send(8'h1C); send(8'hF0); send(8'h1C);
        chk("mkbrk count", 32'(lc_count), 32'd1);
        chk("mkbrk ascii", 32'(lc_ascii), 32'h61);

        // Shift held across one keystroke
        do_reset();
        send(8'h12);
        chk("shift set", 32'(lc_shift), 32'd1);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        chk("shift clr", 32'(lc_shift), 32'd0);
        send(8'h1C);
        chk("shift count", 32'(lc_count), 32'd2);
        chk("shift head0", 32'(lc_ascii), 32'h41);
        chk("shift uc head0", 32'(uc_ascii), 32'h41);
        pop_one();
        chk("shift head1", 32'(lc_ascii), 32'h61);
        chk("shift uc head1", 32'(uc_ascii), 32'h41);

        // Extended make/break swallowed, parser returns to IDLE
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h29);
        chk("ext count", 32'(lc_count), 32'd1);
        chk("ext ascii", 32'(lc_ascii), 32'h20);
        send(8'h1C);
        chk("ext idle", 32'(lc_count), 32'd2);

        // Fill DEPTH=4, overflow, push+pop when full
        do_reset();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        chk("ovf full", 32'(lc_full), 32'd1);
        chk("ovf count", 32'(lc_count), 32'd4);
        chk("ovf flag", 32'(lc_ovf), 32'd1);
        chk("ovf head", 32'(lc_ascii), 32'h61);
        byte_valid = 1'b1; byte_data = 8'h2B; rd_en = 1'b1;
        tick();
        byte_valid = 1'b0; rd_en = 1'b0;
        chk("pushpop count", 32'(lc_count), 32'd4);
        chk("pushpop full", 32'(lc_full), 32'd1);
        exp_q = '{8'h62, 8'h63, 8'h64, 8'h66};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), 32'(lc_ascii), 32'(exp_q[k]));
            pop_one();
        end
        chk("drain empty", 32'(lc_empty), 32'd1);
        chk("drain ascii", 32'(lc_ascii), 32'h00);
        chk("ovf sticky", 32'(lc_ovf), 32'd1);
        pop_one();
        chk("pop empty count", 32'(lc_count), 32'd0);
        byte_valid = 1'b1; byte_data = 8'h1C; rd_en = 1'b1;
        tick();
        byte_valid = 1'b0; rd_en = 1'b0;
        chk("pushpop empty count", 32'(lc_count), 32'd1);
        chk("pushpop empty ascii", 32'(lc_ascii), 32'h61);

        // Auto-repeat of one key
        do_reset();
        send(8'h1B); send(8'h1B); send(8'h1B);
`ifdef TYPEMATIC_FILTER_EN
        chk("typematic count", 32'(lc_count), 32'd1);
`else
        chk("typematic count", 32'(lc_count), 32'd3);
`endif

        // Reset in the middle of a break prefix, with shift held
        do_reset();
        send(8'h12); send(8'hF0);
        rst = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b1;
        send(8'h1C);
        chk("midrst count", 32'(lc_count), 32'd1);
        chk("midrst ascii", 32'(lc_ascii), 32'h61);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
